// File: rtl/compare_tally_unit.sv
// Tallies one-hot comparator outcomes over a window of samples and presents
// one record per window under a valid/ready handshake.
module compare_tally_unit #(
  parameter int WINDOW = 8,
  parameter int CNT_W  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             AGreaterB,
  input  logic             ALesserB,
  input  logic             AEqualB,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] gt_count,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] sample_count,
  output logic [1:0]       majority,
  output logic             err_flag
);

  typedef enum logic {COLLECT = 1'b0, HOLD = 1'b1} state_t;

  state_t           r_state, w_state_n;
  logic [CNT_W-1:0] r_gt, r_lt, r_eq, r_cnt;
  logic             r_err;
  logic [CNT_W-1:0] r_out_gt, r_out_lt, r_out_eq, r_out_cnt;
  logic [1:0]       r_out_maj;
  logic             r_out_err;

  logic             w_acc, w_onehot, w_close, w_hs;
  logic [CNT_W-1:0] w_gt_n, w_lt_n, w_eq_n, w_cnt_n;
  logic             w_err_n;
  logic [1:0]       w_maj_n;

  assign in_ready = (r_state == COLLECT) & ~rst;
  assign w_acc    = in_valid & in_ready;
  assign w_hs     = (r_state == HOLD) & out_ready;
  assign w_onehot = (AGreaterB & ~ALesserB & ~AEqualB) |
                    (~AGreaterB & ALesserB & ~AEqualB) |
                    (~AGreaterB & ~ALesserB & AEqualB);

  // Tallies including the sample offered this cycle, so a closing sample
  // lands in the record it closes.
  assign w_gt_n  = r_gt  + CNT_W'(w_acc & w_onehot & AGreaterB);
  assign w_lt_n  = r_lt  + CNT_W'(w_acc & w_onehot & ALesserB);
  assign w_eq_n  = r_eq  + CNT_W'(w_acc & w_onehot & AEqualB);
  assign w_cnt_n = r_cnt + CNT_W'(w_acc);
  assign w_err_n = r_err | (w_acc & ~w_onehot);

  assign w_close = (r_state == COLLECT) &
                   ((w_acc & (w_cnt_n == CNT_W'(WINDOW))) |
                    (flush & ((r_cnt != '0) | w_acc)));

  always_comb begin
    w_maj_n = 2'b00;
    if      ((w_gt_n > w_lt_n) && (w_gt_n > w_eq_n)) w_maj_n = 2'b01;
    else if ((w_lt_n > w_gt_n) && (w_lt_n > w_eq_n)) w_maj_n = 2'b10;
    else if ((w_eq_n > w_gt_n) && (w_eq_n > w_lt_n)) w_maj_n = 2'b11;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      COLLECT: if (w_close) w_state_n = HOLD;
      HOLD:    if (w_hs)    w_state_n = COLLECT;
      default:              w_state_n = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= COLLECT;
      r_gt      <= '0;
      r_lt      <= '0;
      r_eq      <= '0;
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_out_gt  <= '0;
      r_out_lt  <= '0;
      r_out_eq  <= '0;
      r_out_cnt <= '0;
      r_out_maj <= 2'b00;
      r_out_err <= 1'b0;
    end else begin
      r_state <= w_state_n;
      if (w_hs) begin
        r_gt  <= '0;
        r_lt  <= '0;
        r_eq  <= '0;
        r_cnt <= '0;
        r_err <= 1'b0;
      end else if (w_acc) begin
        r_gt  <= w_gt_n;
        r_lt  <= w_lt_n;
        r_eq  <= w_eq_n;
        r_cnt <= w_cnt_n;
        r_err <= w_err_n;
      end
      // Record fields persist after the handshake; consumers qualify with out_valid.
      if (w_close) begin
        r_out_gt  <= w_gt_n;
        r_out_lt  <= w_lt_n;
        r_out_eq  <= w_eq_n;
        r_out_cnt <= w_cnt_n;
        r_out_maj <= w_maj_n;
        r_out_err <= w_err_n;
      end
    end
  end

  assign out_valid    = (r_state == HOLD);
  assign gt_count     = r_out_gt;
  assign lt_count     = r_out_lt;
  assign eq_count     = r_out_eq;
  assign sample_count = r_out_cnt;
  assign majority     = r_out_maj;
  assign err_flag     = r_out_err;

endmodule
